// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with pending-write scoreboard and debug port
// Optional write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] Destination_select,
  input  logic [WIDTH-1:0]  DATA,
  input  logic [ADDR_W-1:0] Source_select_0,
  input  logic [ADDR_W-1:0] Source_select_1,
  output logic [WIDTH-1:0]  out_0,
  output logic [WIDTH-1:0]  out_1,
  output logic              busy_0,
  output logic              busy_1,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [WIDTH-1:0]  dbg_wdata,
  output logic              dbg_ack,
  output logic [WIDTH-1:0]  dbg_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, ACK} dbg_state_t;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_next;
  dbg_state_t       state;
  dbg_state_t       state_next;
  logic             dbg_accept;
  logic             core_wr_ok;
  logic             dbg_wr_ok;

  // Core writeback always wins; debug is only accepted on a cycle without one.
  assign dbg_accept = (state == IDLE) && dbg_req && !write_enable;
  assign core_wr_ok = write_enable && !(ZERO_REG != 0 && Destination_select == '0);
  assign dbg_wr_ok  = dbg_accept && dbg_we && !(ZERO_REG != 0 && dbg_addr == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (core_wr_ok) begin
      regs[Destination_select] <= DATA;
    end else if (dbg_wr_ok) begin
      regs[dbg_addr] <= dbg_wdata;
    end
  end

  // Issue is applied after the clear so a new producer on the same index wins.
  always_comb begin
    pending_next = pending;
    if (write_enable) pending_next[Destination_select] = 1'b0;
    if (issue_valid) pending_next[issue_dest] = 1'b1;
    if (ZERO_REG != 0) pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

  always_ff @(posedge clk) begin
    if (reset) dbg_rdata <= '0;
    else if (dbg_accept && !dbg_we) dbg_rdata <= regs[dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dbg_accept) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dbg_ack = (state == ACK);
  end

  always_comb begin
    out_0  = (ZERO_REG != 0 && Source_select_0 == '0) ? '0 : regs[Source_select_0];
    out_1  = (ZERO_REG != 0 && Source_select_1 == '0) ? '0 : regs[Source_select_1];
    busy_0 = pending[Source_select_0];
    busy_1 = pending[Source_select_1];
`ifdef REGFILE_BYPASS_EN
    if (core_wr_ok && Source_select_0 == Destination_select) begin
      out_0  = DATA;
      busy_0 = 1'b0;
    end
    if (core_wr_ok && Source_select_1 == Destination_select) begin
      out_1  = DATA;
      busy_1 = 1'b0;
    end
`endif
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

- Parametrised successor to the core's 32×32 integer register file.
- Adds the following to the existing two combinational read ports and one write port:
  - configurable width and depth;
  - optional hardwired zero register;
  - a per-register pending-write scoreboard for the pipelined core's hazard unit;
  - a handshaked debug read/write port that yields to core writebacks.
- Sits between decode (read/issue) and writeback.
- The UART debug monitor accesses it through the debug port.

## Interface
Parameters:
- WIDTH, 32, register data width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores all writes

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- write_enable  in  1  core writeback strobe
- Destination_select  in  ADDR_W  core writeback index
- DATA  in  WIDTH  core writeback data
- Source_select_0 / Source_select_1  in  ADDR_W  read indices
- out_0 / out_1  out  WIDTH  combinational read data
- busy_0 / busy_1  out  1  pending bit of the selected source register (0 for reg 0 when ZERO_REG)
- issue_valid  in  1  instruction with a destination issued this cycle
- issue_dest  in  ADDR_W  destination of the issued instruction
- dbg_req  in  1  debug access request, held until dbg_ack
- dbg_we  in  1  1 = debug write, 0 = debug read
- dbg_addr  in  ADDR_W  debug register index
- dbg_wdata  in  WIDTH  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  WIDTH  registered debug read data, valid from dbg_ack onward

## Operation
- Register array: DEPTH×WIDTH flops.
  - Core write at the edge where write_enable=1.
  - Destination 0 is discarded when ZERO_REG=1.
- Reads are combinational. Index 0 returns 0 when ZERO_REG=1.
- Scoreboard: DEPTH pending bits.
  - An edge with issue_valid sets pending[issue_dest].
  - An edge with write_enable clears pending[Destination_select].
  - Same index in both on the same edge: set wins (new producer issued).
  - pending[0] is never set when ZERO_REG=1.
  - Debug writes do not touch pending.
- Debug FSM, states IDLE and ACK:
  - IDLE, dbg_req=1, write_enable=0: accept the access.
    - Write: performs the write at that edge.
    - Read: captures the array value at dbg_addr into dbg_rdata at that edge; the bypass is not applied.
    - Go to ACK.
  - IDLE, dbg_req=1, write_enable=1: stall and stay in IDLE. The core always has priority; debug may starve indefinitely.
  - ACK: dbg_ack=1 for exactly this cycle. dbg_req is ignored. Return to IDLE.
- Reset values:
  - every register, every pending bit and dbg_rdata: 0
  - FSM: IDLE; dbg_ack: 0
  - out_*: 0 after reset (bypass excepted); busy_*: 0

## Timing
- Read latency: 0 cycles (combinational from Source_select_*).
- Core write visible on out_* the cycle after the write edge. With bypass, it is visible in the same cycle.
- busy_* reflects a set or clear the cycle after the issue/writeback edge.
- Debug access: minimum 2 cycles (accept edge, then ACK cycle). Back-to-back debug accesses are accepted at most every 2 cycles.
- Reset asserted during ACK: dbg_ack is 0 the next cycle and the FSM is IDLE. A debug write already performed at the accept edge is then cleared by the reset.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - If write_enable=1 and Source_select_n == Destination_select (nonzero, or any index when ZERO_REG=0), out_n = DATA in that cycle.
  - busy_n is also forced to 0 in that case.
- Undefined: out_n and busy_n show pre-write state until the edge.

## Test plan
- Reset, then read all indices -> out_0/out_1 = 0, busy_* = 0, dbg_ack = 0.
- Write 0xDEADBEEF to reg 5, then read reg 5 -> 0xDEADBEEF next cycle. Write 0x1234 to reg 0 with ZERO_REG=1 -> reads 0.
- Same-cycle write 0xA5A5A5A5 to reg 7 with Source_select_0=7:
  - REGFILE_BYPASS_EN defined -> out_0 = 0xA5A5A5A5 in that cycle.
  - Undefined -> old value, new value next cycle.
- Issue dest 3 -> busy_0(sel 3) = 1. Writeback reg 3 -> busy_0 = 0. Issue and writeback dest 3 on the same edge -> busy_0 stays 1.
- Debug read of reg 5 (0xDEADBEEF) with write_enable high for 3 cycles -> dbg_ack delayed 3 cycles, then dbg_ack one cycle, dbg_rdata = 0xDEADBEEF.
- Debug write 0x55 to reg 9, reset asserted during the ACK cycle -> dbg_ack = 0 next cycle, reg 9 reads 0.
